host_cfg_sink: RTL and testbench

- Device-side responder for the host configuration channel: accepts 256-bit config words on a valid/accept handshake.
- Decodes each word and drives a downstream trigger-table write port.
- Maintains the per-entry valid bitmap, the global trade enable and a saturating error counter.
- Sits between the host channel and the tick-to-trade trigger table.

---
 rtl/host_cfg_pkg.sv | 26 ++
 rtl/host_cfg_decode.sv | 32 +++
 rtl/host_cfg_sink.sv | 92 +++++++++
 tb/tb_host_cfg_sink.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/host_cfg_pkg.sv
// host_cfg_pkg: shared opcodes, states, command struct, word field positions and the check-byte helper.
// The check byte is only consulted when HOST_CFG_CHECK_EN is defined.
package host_cfg_pkg;
  typedef enum logic [7:0] {
    OP_WRITE      = 8'h01,
    OP_CLEAR      = 8'h02,
    OP_CLEAR_ALL  = 8'h03,
    OP_SET_ENABLE = 8'h04
  } op_e;
  typedef enum logic {IDLE, SWEEP} state_e;
  typedef enum logic [2:0] {CMD_ERR, CMD_WRITE, CMD_CLEAR, CMD_CLEAR_ALL, CMD_SET_EN} cmd_e;
  typedef struct packed {
    cmd_e       kind;
    logic [7:0] idx;
    logic       en;
  } cmd_t;
  localparam int OP_LSB   = 248;
  localparam int IDX_LSB  = 240;
  localparam int CHK_LSB  = 232;
  localparam int CHK_BYTE = 29;
  // XOR of every byte except the check byte itself
  function automatic logic [7:0] check_byte(input logic [255:0] w);
    check_byte = '0;
    for (int i = 0; i < 32; i++) if (i != CHK_BYTE) check_byte ^= w[i*8 +: 8];
  endfunction
endpackage

// File: rtl/host_cfg_decode.sv
// host_cfg_decode: combinational field extract and opcode/range/check classification of a host config word.
// Macro HOST_CFG_CHECK_EN enables the check-byte test, which overrides opcode decode.
module host_cfg_decode
  import host_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic [255:0] word,
  output cmd_t         cmd
);
  logic [7:0] op;
  logic [7:0] idx;
  logic       in_range;
  logic       chk_ok;
  assign op       = word[OP_LSB +: 8];
  assign idx      = word[IDX_LSB +: 8];
  assign in_range = 32'(idx) < NUM_ENTRIES;
`ifdef HOST_CFG_CHECK_EN
  assign chk_ok = word[CHK_LSB +: 8] == check_byte(word);
`else
  assign chk_ok = 1'b1;
`endif
  always_comb begin
    cmd.idx  = idx;
    cmd.en   = word[0];
    cmd.kind = !chk_ok              ? CMD_ERR :
               op == OP_WRITE       ? (in_range ? CMD_WRITE : CMD_ERR) :
               op == OP_CLEAR       ? (in_range ? CMD_CLEAR : CMD_ERR) :
               op == OP_CLEAR_ALL   ? CMD_CLEAR_ALL :
               op == OP_SET_ENABLE  ? CMD_SET_EN : CMD_ERR;
  end
endmodule

// File: rtl/host_cfg_sink.sv
// host_cfg_sink: host config channel responder driving the trigger-table write port, valid bitmap, enable and error count.
// Optional macro HOST_CFG_CHECK_EN adds check-byte validation in host_cfg_decode.
module host_cfg_sink
  import host_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int DATA_W      = 64,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_config_valid,
  input  logic [255:0]                   in_config_data,
  output logic                           in_config_accept,
  output logic                           tbl_wr_en,
  output logic [$clog2(NUM_ENTRIES)-1:0] tbl_wr_idx,
  output logic [DATA_W-1:0]              tbl_wr_data,
  output logic [NUM_ENTRIES-1:0]         entry_valid,
  output logic                           trade_enable,
  output logic                           cfg_busy,
  output logic [ERR_CNT_W-1:0]           cfg_err_cnt
);
  localparam int IW = $clog2(NUM_ENTRIES);
  cmd_t          cmd;
  state_e        state;
  logic [IW-1:0] sweep_idx;
  logic [IW-1:0] idx;
  logic          xfer;
  host_cfg_decode #(.NUM_ENTRIES(NUM_ENTRIES)) u_decode (
    .word (in_config_data),
    .cmd  (cmd)
  );
  assign idx  = cmd.idx[IW-1:0];
  assign xfer = in_config_valid && in_config_accept;
  // The clear-all transfer edge issues entry 0 itself, so the sweep spans exactly NUM_ENTRIES cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      sweep_idx        <= '0;
      in_config_accept <= 1'b0;
      tbl_wr_en        <= 1'b0;
      tbl_wr_idx       <= '0;
      tbl_wr_data      <= '0;
      entry_valid      <= '0;
      trade_enable     <= 1'b0;
      cfg_busy         <= 1'b0;
      cfg_err_cnt      <= '0;
    end else begin
      tbl_wr_en <= 1'b0;
      if (state == SWEEP) begin
        tbl_wr_en              <= 1'b1;
        tbl_wr_idx             <= sweep_idx;
        tbl_wr_data            <= '0;
        entry_valid[sweep_idx] <= 1'b0;
        sweep_idx              <= sweep_idx + 1'b1;
        if (&sweep_idx) state <= IDLE;
      end else begin
        in_config_accept <= 1'b1;
        cfg_busy         <= 1'b0;
        if (xfer) begin
          case (cmd.kind)
            CMD_WRITE: begin
              tbl_wr_en        <= 1'b1;
              tbl_wr_idx       <= idx;
              tbl_wr_data      <= in_config_data[DATA_W-1:0];
              entry_valid[idx] <= 1'b1;
            end
            CMD_CLEAR: begin
              tbl_wr_en        <= 1'b1;
              tbl_wr_idx       <= idx;
              tbl_wr_data      <= '0;
              entry_valid[idx] <= 1'b0;
            end
            CMD_CLEAR_ALL: begin
              state            <= SWEEP;
              in_config_accept <= 1'b0;
              cfg_busy         <= 1'b1;
              trade_enable     <= 1'b0;
              tbl_wr_en        <= 1'b1;
              tbl_wr_idx       <= '0;
              tbl_wr_data      <= '0;
              entry_valid[0]   <= 1'b0;
              sweep_idx        <= IW'(1);
            end
            CMD_SET_EN: trade_enable <= cmd.en;
            default: if (cfg_err_cnt != '1) cfg_err_cnt <= cfg_err_cnt + 1'b1;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_host_cfg_sink.sv
// tb_host_cfg_sink: directed stimulus with a write-port scoreboard for host_cfg_sink (NUM_ENTRIES=16, DATA_W=64, ERR_CNT_W=4).
// Check-byte corruption is exercised only when HOST_CFG_CHECK_EN is defined.
module tb_host_cfg_sink;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_config_valid = 1'b0;
  logic [255:0] in_config_data = '0;
  logic         in_config_accept;
  logic         tbl_wr_en;
  logic [3:0]   tbl_wr_idx;
  logic [63:0]  tbl_wr_data;
  logic [15:0]  entry_valid;
  logic         trade_enable;
  logic         cfg_busy;
  logic [3:0]   cfg_err_cnt;
  int total = 0;
  int bad = 0;
  int n;
  int bc;
  logic [67:0] sbq[$];

  host_cfg_sink #(.NUM_ENTRIES(16), .DATA_W(64), .ERR_CNT_W(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_config_valid  (in_config_valid),
    .in_config_data   (in_config_data),
    .in_config_accept (in_config_accept),
    .tbl_wr_en        (tbl_wr_en),
    .tbl_wr_idx       (tbl_wr_idx),
    .tbl_wr_data      (tbl_wr_data),
    .entry_valid      (entry_valid),
    .trade_enable     (trade_enable),
    .cfg_busy         (cfg_busy),
    .cfg_err_cnt      (cfg_err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mk(input logic [7:0] op, input logic [7:0] idx, input logic [63:0] d);
    logic [255:0] w;
    logic [7:0] c;
    w = '0;
    w[255:248] = op;
    w[247:240] = idx;
    w[63:0] = d;
    c = '0;
    for (int i = 0; i < 32; i++) if (i != 29) c ^= w[i*8 +: 8];
    w[239:232] = c;
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic exp_wr(input logic [3:0] idx, input logic [63:0] d);
    sbq.push_back({idx, d});
  endtask

  // Holds the word valid until accepted; returns at transfer edge + 1 with valid dropped, cnt = negedges waited
  task automatic send(input logic [255:0] w, output int cnt);
    in_config_data = w;
    in_config_valid = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!in_config_accept && cnt < 100);
    if (!in_config_accept) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    @(posedge clk);
    #1;
    in_config_valid = 1'b0;
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (tbl_wr_en) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected got idx=%0d data=%0h exp=no_write", tbl_wr_idx, tbl_wr_data);
      end else begin
        logic [67:0] e;
        e = sbq.pop_front();
        if ({tbl_wr_idx, tbl_wr_data} !== e) begin
          bad++;
          $display("FAIL wr_match got idx=%0d data=%0h exp idx=%0d data=%0h",
                   tbl_wr_idx, tbl_wr_data, e[67:64], e[63:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("rst_accept", in_config_accept, 0);
    chk("rst_outputs", {tbl_wr_en, tbl_wr_idx, tbl_wr_data, entry_valid, trade_enable, cfg_busy, cfg_err_cnt}, 0);
    reset_n = 1'b1;
    chk("accept_before_edge", in_config_accept, 0);
    tick(1);
    chk("accept_first_edge", in_config_accept, 1);

    exp_wr(5, 64'hDEAD_BEEF);
    send(mk(8'h01, 8'd5, 64'hDEAD_BEEF), n);
    chk("wr_latency", tbl_wr_en, 1);
    chk("ev_write5", entry_valid, 16'h0020);
    tick(1);
    chk("wr_pulse_end", tbl_wr_en, 0);
    chk("wr_idx_hold", tbl_wr_idx, 5);

    exp_wr(5, 0);
    send(mk(8'h02, 8'd5, 64'h1234), n);
    for (int i = 0; i < 4; i++) begin
      exp_wr(4'(i), 64'h100 + 64'(i));
      send(mk(8'h01, 8'(i), 64'h100 + 64'(i)), n);
      chk("b2b_one_cycle", n, 1);
    end
    chk("b2b_accept", in_config_accept, 1);
    chk("ev_b2b", entry_valid, 16'h000F);
    send(mk(8'h04, 8'hAA, 64'h1), n);
    chk("set_enable", trade_enable, 1);

    exp_wr(7, 64'h77);
    exp_wr(7, 0);
    send(mk(8'h01, 8'd7, 64'h77), n);
    send(mk(8'h02, 8'd7, 64'h0), n);
    tick(1);
    chk("ev_wr_clr", entry_valid, 16'h000F);

    for (int i = 0; i < 16; i++) exp_wr(4'(i), 0);
    send(mk(8'h03, 8'h99, 64'hFFFF), n);
    chk("sweep_accept_low", in_config_accept, 0);
    chk("sweep_busy", cfg_busy, 1);
    chk("sweep_te_off", trade_enable, 0);
    exp_wr(9, 64'h55);
    bc = 0;
    fork
      send(mk(8'h01, 8'd9, 64'h55), n);
      repeat (20) begin
        @(negedge clk);
        if (cfg_busy) bc++;
      end
    join
    tick(1);
    chk("held_word_wait", n, 17);
    chk("busy_cycles", bc, 16);
    chk("ev_after_sweep", entry_valid, 16'h0200);

    send(mk(8'h7F, 8'd0, 64'h0), n);
    send(mk(8'h01, 8'd16, 64'h1), n);
    send(mk(8'h02, 8'd200, 64'h1), n);
    chk("err_cnt3", cfg_err_cnt, 3);
    chk("ev_err_unchanged", entry_valid, 16'h0200);
    for (int i = 0; i < 20; i++) begin
      send(mk(8'hF0, 8'd0, 64'h0), n);
      if (i == 10) chk("err_cnt14", cfg_err_cnt, 14);
      if (i == 11) chk("err_cnt15", cfg_err_cnt, 15);
    end
    chk("err_saturated", cfg_err_cnt, 15);

    for (int i = 0; i < 6; i++) exp_wr(4'(i), 0);
    send(mk(8'h03, 8'd0, 64'h0), n);
    repeat (6) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {in_config_accept, tbl_wr_en, tbl_wr_idx, tbl_wr_data, entry_valid, trade_enable, cfg_busy, cfg_err_cnt}, 0);
    tick(3);
    reset_n = 1'b1;
    tick(1);
    chk("midrst_accept", in_config_accept, 1);
    tick(3);
    chk("midrst_no_writes", sbq.size(), 0);

`ifdef HOST_CFG_CHECK_EN
    begin
      logic [255:0] w;
      w = mk(8'h01, 8'd3, 64'h33);
      w[239:232] = w[239:232] ^ 8'h5A;
      send(w, n);
      tick(1);
      chk("chk_err_cnt", cfg_err_cnt, 1);
      chk("chk_ev", entry_valid, 0);
    end
`endif

    exp_wr(15, 64'h1234);
    send(mk(8'h01, 8'd15, 64'h1234), n);
    chk("ev_last_entry", entry_valid, 16'h8000);
    tick(2);
    chk("sb_drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
